// File: rtl/acc_feeder.sv
// Operand sequencer for the accumulator core: reads a run of N operands from a
// synchronous-read memory and streams them on run/valid/number, then pulses done.
module acc_feeder #(
    parameter int IN_DATA_WIDTH = 8,
    parameter int AWIDTH        = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start_i,
    input  logic [AWIDTH-1:0]        base_addr_i,
    input  logic [AWIDTH-1:0]        num_cnt_i,
    output logic                     ce_o,
    output logic [AWIDTH-1:0]        addr_o,
    input  logic [IN_DATA_WIDTH-1:0] q_i,
    output logic                     run_o,
    output logic                     valid_o,
    output logic [IN_DATA_WIDTH-1:0] number_o,
    output logic                     idle_o,
    output logic                     done_o,
    output logic [1:0]               state_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [AWIDTH-1:0] r_addr;
    logic [AWIDTH-1:0] r_cnt;
    logic              r_valid;

    // Handshake: start_i is a request taken only in IDLE (no ready/backpressure);
    // valid_o marks each data beat on number_o and is only ever high while run_o is high.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = (num_cnt_i != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                if (r_cnt == AWIDTH'(1)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Memory returns data one cycle after the read, so valid lags ce by one.
            r_valid <= (r_state == S_FETCH);
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_addr <= base_addr_i;
                        r_cnt  <= num_cnt_i;
                    end
                end
                S_FETCH: begin
                    r_addr <= r_addr + AWIDTH'(1);
                    r_cnt  <= r_cnt - AWIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    assign ce_o     = (r_state == S_FETCH);
    assign run_o    = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign idle_o   = (r_state == S_IDLE);
    assign done_o   = (r_state == S_DONE);
    assign addr_o   = r_addr;
    assign valid_o  = r_valid;
    assign number_o = q_i;
    assign state_o  = r_state;

endmodule

// File: tb/tb_acc_feeder.sv
// Self-checking bench for acc_feeder: memory model, cycle-exact directed runs and
// a scoreboard of expected addresses, data beats and per-run sums.
module tb_acc_feeder;

  logic       clk;
  logic       reset_n;
  logic       start_i;
  logic [7:0] base_addr_i;
  logic [7:0] num_cnt_i;
  logic       ce_o;
  logic [7:0] addr_o;
  logic [7:0] q_i;
  logic       run_o;
  logic       valid_o;
  logic [7:0] number_o;
  logic       idle_o;
  logic       done_o;
  logic [1:0] state_o;

  logic [7:0] mem [256];

  logic [7:0]  exp_addr_q[$];
  logic [7:0]  exp_data_q[$];
  logic [31:0] exp_n_q[$];
  logic [31:0] exp_sum_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int mon_beats = 0;
  int mon_sum = 0;

  acc_feeder #(.IN_DATA_WIDTH(8), .AWIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i),
    .base_addr_i(base_addr_i), .num_cnt_i(num_cnt_i),
    .ce_o(ce_o), .addr_o(addr_o), .q_i(q_i),
    .run_o(run_o), .valid_o(valid_o), .number_o(number_o),
    .idle_o(idle_o), .done_o(done_o), .state_o(state_o)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ce_o) q_i <= mem[addr_o];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [7:0] base, input logic [7:0] n);
    logic [7:0] a;
    int sum;
    sum = 0;
    for (int k = 0; k < int'(n); k++) begin
      a = base + 8'(k);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(mem[a]);
      sum += int'(mem[a]);
    end
    exp_n_q.push_back(32'(n));
    exp_sum_q.push_back(32'(sum));
  endtask

  // One run, checked cycle by cycle; optionally holds start_i high and scrambles
  // base/count during the run to prove they are latched once.
  task automatic do_run(input logic [7:0] base, input logic [7:0] n, input bit hold);
    int last;
    int ni;
    ni = int'(n);
    @(negedge clk);
    check_eq("idle_before_start", 32'(idle_o), 1);
    base_addr_i = base;
    num_cnt_i   = n;
    start_i     = 1'b1;
    push_exp(base, n);
    last = (ni == 0) ? 1 : ni + 2;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (hold) begin
        num_cnt_i   = 8'($urandom_range(0, 255));
        base_addr_i = 8'($urandom_range(0, 255));
      end else begin
        start_i = 1'b0;
      end
      check_eq("ce", 32'(ce_o), 32'(c <= ni));
      if (c <= ni) check_eq("addr_cycle", 32'(addr_o), 32'(8'(base + 8'(c - 1))));
      check_eq("run", 32'(run_o), 32'((ni != 0) && (c <= ni + 1)));
      check_eq("valid", 32'(valid_o), 32'((c >= 2) && (c <= ni + 1)));
      check_eq("done", 32'(done_o), 32'(c == last));
      check_eq("idle_busy", 32'(idle_o), 0);
    end
    if (hold) begin
      @(negedge clk);
      check_eq("idle_after_hold", 32'(idle_o), 1);
      start_i = 1'b0;
      @(negedge clk);
      check_eq("no_rerun_ce", 32'(ce_o), 0);
      check_eq("no_rerun_idle", 32'(idle_o), 1);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if (ce_o) begin
        check_eq("addr_q_avail", 32'(exp_addr_q.size() != 0), 1);
        if (exp_addr_q.size() != 0) check_eq("sb_addr", 32'(addr_o), 32'(exp_addr_q.pop_front()));
      end
      if (valid_o) begin
        check_eq("valid_in_run", 32'(run_o), 1);
        check_eq("data_q_avail", 32'(exp_data_q.size() != 0), 1);
        if (exp_data_q.size() != 0) check_eq("sb_data", 32'(number_o), 32'(exp_data_q.pop_front()));
        mon_beats++;
        mon_sum += int'(number_o);
      end
      if (done_o) begin
        check_eq("done_no_run", 32'(run_o), 0);
        check_eq("run_q_avail", 32'(exp_n_q.size() != 0), 1);
        if (exp_n_q.size() != 0) begin
          check_eq("beat_count", 32'(mon_beats), exp_n_q.pop_front());
          check_eq("acc_sum", 32'(mon_sum), exp_sum_q.pop_front());
        end
        mon_beats = 0;
        mon_sum   = 0;
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd3; mem[3] = 8'd4;
    q_i = '0;
    reset_n = 1'b0;
    start_i = 1'b0;
    base_addr_i = '0;
    num_cnt_i = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst_idle", 32'(idle_o), 1);
    check_eq("rst_ce", 32'(ce_o), 0);
    check_eq("rst_run", 32'(run_o), 0);
    check_eq("rst_valid", 32'(valid_o), 0);
    check_eq("rst_done", 32'(done_o), 0);
    check_eq("rst_addr", 32'(addr_o), 0);

    do_run(8'd0, 8'd4, 1'b0);      // sum 1+2+3+4 = 10
    do_run(8'd77, 8'd0, 1'b0);     // done-only run
    do_run(8'd254, 8'd4, 1'b0);    // address wrap
    do_run(8'd20, 8'd6, 1'b1);     // start held, count scrambled

    // reset in the middle of FETCH after two beats
    @(negedge clk);
    base_addr_i = 8'd100; num_cnt_i = 8'd5; start_i = 1'b1;
    push_exp(8'd100, 8'd5);
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    check_eq("mid_ce", 32'(ce_o), 1);
    check_eq("mid_addr", 32'(addr_o), 101);
    #2 reset_n = 1'b0;
    #1;
    check_eq("abort_ce", 32'(ce_o), 0);
    check_eq("abort_run", 32'(run_o), 0);
    check_eq("abort_valid", 32'(valid_o), 0);
    check_eq("abort_done", 32'(done_o), 0);
    check_eq("abort_idle", 32'(idle_o), 1);
    check_eq("abort_addr", 32'(addr_o), 0);
    exp_addr_q.delete(); exp_data_q.delete(); exp_n_q.delete(); exp_sum_q.delete();
    mon_beats = 0; mon_sum = 0;
    repeat (2) begin
      @(negedge clk);
      check_eq("abort_no_done", 32'(done_o), 0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_done", 32'(done_o), 0);

    do_run(8'd30, 8'd3, 1'b0);
    do_run(8'd40, 8'd5, 1'b0);     // back-to-back
    do_run(8'd50, 8'd2, 1'b0);
    do_run(8'd7, 8'd255, 1'b0);    // maximum run length

    for (int r = 0; r < 6; r++) begin
      do_run(8'($urandom_range(0, 255)), 8'($urandom_range(0, 20)), 1'b0);
    end

    repeat (3) @(negedge clk);
    check_eq("addr_q_empty", 32'(exp_addr_q.size()), 0);
    check_eq("data_q_empty", 32'(exp_data_q.size()), 0);
    check_eq("run_q_empty", 32'(exp_n_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
